// File: rtl/edge_detect_multi.sv
// edge_detect_multi: multi-channel synchronise + debounce + edge detector.
// Each channel has its own synchroniser, debounce counter, registered edge
// pulse and saturating event counter. The edge-select mode and the counter
// clear are shared by all channels.
module edge_detect_multi #(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CHANNELS-1:0]           signal,
  input  logic [1:0]                    mode,
  input  logic                          clear,
  output logic [CHANNELS-1:0]           outedge,
  output logic [CHANNELS-1:0]           level,
  output logic [CHANNELS*CNT_WIDTH-1:0] edge_count,
  output logic [CHANNELS-1:0]           overflow
);

  // Debounce counter is wide enough to hold DEBOUNCE_CYCLES; it only ever
  // reaches DEBOUNCE_CYCLES-1 before the level is accepted.
  localparam int                  DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0]     DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  // Synchroniser chain: bit 0 is the first flop, bit SYNC_STAGES-1 the last.
  logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
  logic [SYNC_STAGES-1:0] sync_d [CHANNELS];
  logic [CHANNELS-1:0]    sync_out;

  // Debounce state.
  logic [DB_W-1:0]        db_q   [CHANNELS];
  logic [DB_W-1:0]        db_d   [CHANNELS];
  logic [CHANNELS-1:0]    level_q;
  logic [CHANNELS-1:0]    level_d;

  // Edge pulse.
  logic [CHANNELS-1:0]    outedge_q;
  logic [CHANNELS-1:0]    outedge_d;

  // Event counters and sticky saturation flags.
  logic [CNT_WIDTH-1:0]   cnt_q  [CHANNELS];
  logic [CNT_WIDTH-1:0]   cnt_d  [CHANNELS];
  logic [CHANNELS-1:0]    ovf_q;
  logic [CHANNELS-1:0]    ovf_d;

  // Shift each raw input into its synchroniser; only the last stage is used.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      sync_d[i]   = {sync_q[i][SYNC_STAGES-2:0], signal[i]};
      sync_out[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  // Debounce: a new level is accepted after DEBOUNCE_CYCLES consecutive
  // mismatching samples; any return to the current level restarts the count.
  // The edge pulse is decided on the same edge the level flips, so it lines
  // up with the new level. A change masked by mode is simply dropped.
  always_comb begin
    level_d   = level_q;
    outedge_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      db_d[i] = db_q[i];
      if (sync_out[i] == level_q[i]) begin
        db_d[i] = '0;
      end else if (db_q[i] == DB_LAST) begin
        db_d[i]      = '0;
        level_d[i]   = sync_out[i];
        outedge_d[i] = sync_out[i] ? mode[0] : mode[1];
      end else begin
        db_d[i] = db_q[i] + DB_W'(1);
      end
    end
  end

  // Counters follow the registered pulse one edge later. At the top value the
  // count holds and the overflow flag latches. Clear beats a simultaneous
  // increment.
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (outedge_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // State registers for synchroniser, debounce, pulse and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i] <= '0;
        db_q[i]   <= '0;
        cnt_q[i]  <= '0;
      end
      level_q   <= '0;
      outedge_q <= '0;
      ovf_q     <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i] <= sync_d[i];
        db_q[i]   <= db_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      level_q   <= level_d;
      outedge_q <= outedge_d;
      ovf_q     <= ovf_d;
    end
  end

  // Pack the per-channel counters onto the flat output bus.
  always_comb begin
    edge_count = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      edge_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end
  end

  assign outedge  = outedge_q;
  assign level    = level_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Testbench for edge_detect_multi: random channel activity compared every
// cycle against a cycle-level behavioural model of the channel rules.
module tb_edge_detect_multi;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int CW = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic             clk;
  logic             rst_n;
  logic [CH-1:0]    signal;
  logic [1:0]       mode;
  logic             clear;
  logic [CH-1:0]    outedge;
  logic [CH-1:0]    level;
  logic [CH*CW-1:0] edge_count;
  logic [CH-1:0]    overflow;

  int checks = 0;
  int errors = 0;

  // Model state: input history per channel, consecutive-mismatch run length,
  // accepted level, pending pulse, event count and sticky saturation flag.
  logic [CH-1:0] hist [SS];
  int            mRun  [CH];
  int            mCnt  [CH];
  logic [CH-1:0] mLevel;
  logic [CH-1:0] mPulse;
  logic [CH-1:0] mOvf;

  edge_detect_multi #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .signal(signal), .mode(mode), .clear(clear),
    .outedge(outedge), .level(level), .edge_count(edge_count),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h t=%0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int s = 0; s < SS; s++) hist[s] = '0;
    for (int c = 0; c < CH; c++) begin
      mRun[c] = 0;
      mCnt[c] = 0;
    end
    mLevel = '0;
    mPulse = '0;
    mOvf   = '0;
  endtask

  // One clock edge of the model. The synchroniser is a pure SS-cycle delay;
  // the level flips once the delayed input has disagreed with it on DB
  // consecutive edges.
  task automatic modelStep(input logic [CH-1:0] sig, input logic [1:0] md,
                           input logic clr);
    logic [CH-1:0] delayed;
    logic [CH-1:0] nextPulse;
    delayed   = hist[SS-1];
    nextPulse = '0;
    for (int c = 0; c < CH; c++) begin
      if (clr) begin
        mCnt[c] = 0;
        mOvf[c] = 1'b0;
      end else if (mPulse[c]) begin
        if (mCnt[c] == CMAX) mOvf[c] = 1'b1;
        else mCnt[c] = mCnt[c] + 1;
      end
      if (delayed[c] != mLevel[c]) begin
        mRun[c] = mRun[c] + 1;
        if (mRun[c] == DB) begin
          mRun[c]      = 0;
          mLevel[c]    = delayed[c];
          nextPulse[c] = delayed[c] ? md[0] : md[1];
        end
      end else begin
        mRun[c] = 0;
      end
    end
    mPulse = nextPulse;
    for (int s = SS - 1; s > 0; s--) hist[s] = hist[s-1];
    hist[0] = sig;
  endtask

  task automatic checkAll();
    logic [CH*CW-1:0] expCount;
    for (int c = 0; c < CH; c++) expCount[c*CW +: CW] = CW'(mCnt[c]);
    checkOutput("level",    32'(level),      32'(mLevel));
    checkOutput("outedge",  32'(outedge),    32'(mPulse));
    checkOutput("count",    32'(edge_count), 32'(expCount));
    checkOutput("overflow", 32'(overflow),   32'(mOvf));
  endtask

  // Drive one cycle of inputs at the falling edge, step the model on the
  // rising edge and compare shortly after it.
  task automatic applyStimulus(input logic [CH-1:0] sig, input logic [1:0] md,
                               input logic clr, input logic rstn);
    @(negedge clk);
    signal = sig;
    mode   = md;
    clear  = clr;
    rst_n  = rstn;
    @(posedge clk);
    if (rst_n) modelStep(sig, md, clr);
    else modelReset();
    #1;
    checkAll();
  endtask

  logic [CH-1:0] curSig;
  logic [1:0]    curMode;
  int            hold [CH];
  bit            found;

  initial begin
    signal = '0;
    mode   = 2'b01;
    clear  = 1'b0;
    rst_n  = 1'b1;
    modelReset();
    #1 rst_n = 1'b0;
    #4;
    checkAll();

    repeat (3) applyStimulus('0, 2'b01, 1'b0, 1'b0);

    // Rising detection on channel 0, then falling-only and both modes.
    repeat (12) applyStimulus(4'b0001, 2'b01, 1'b0, 1'b1);
    repeat (12) applyStimulus(4'b0000, 2'b10, 1'b0, 1'b1);
    repeat (12) applyStimulus(4'b0001, 2'b10, 1'b0, 1'b1);
    repeat (12) applyStimulus(4'b1110, 2'b11, 1'b0, 1'b1);
    repeat (12) applyStimulus(4'b0001, 2'b11, 1'b0, 1'b1);
    // Short glitches (3 cycles) then an exactly-long-enough pulse (4 cycles).
    repeat (3)  applyStimulus(4'b0011, 2'b11, 1'b0, 1'b1);
    repeat (10) applyStimulus(4'b0001, 2'b11, 1'b0, 1'b1);
    repeat (4)  applyStimulus(4'b0011, 2'b11, 1'b0, 1'b1);
    repeat (12) applyStimulus(4'b0001, 2'b11, 1'b0, 1'b1);

    // Random activity: each channel holds a value 1..9 cycles so that both
    // glitches and accepted edges occur; mode and clear change occasionally.
    curSig  = '0;
    curMode = 2'b11;
    for (int c = 0; c < CH; c++) hold[c] = 1;
    for (int n = 0; n < 2500; n++) begin
      for (int c = 0; c < CH; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          curSig[c] = ~curSig[c];
          hold[c]   = int'($urandom_range(1, 9));
        end
      end
      if ($urandom_range(0, 59) == 0) curMode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 && curMode == 2'b00) curMode = 2'b11;
      applyStimulus(curSig, curMode, ($urandom_range(0, 299) == 0), 1'b1);
    end
    // Clear coincident with activity and all channels toggling together.
    repeat (12) applyStimulus('0, 2'b11, 1'b0, 1'b1);
    repeat (5)  applyStimulus('1, 2'b11, 1'b0, 1'b1);
    applyStimulus('1, 2'b11, 1'b1, 1'b1);
    applyStimulus('1, 2'b11, 1'b1, 1'b1);
    repeat (6)  applyStimulus('1, 2'b11, 1'b0, 1'b1);

    // Asynchronous reset while a pulse is high.
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      applyStimulus(((k / 8) % 2 == 0) ? 4'b0000 : 4'b1111, 2'b11, 1'b0, 1'b1);
      if (outedge != '0) found = 1'b1;
    end
    checkOutput("wait_outedge", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    repeat (2) applyStimulus('1, 2'b01, 1'b0, 1'b0);
    repeat (12) applyStimulus('1, 2'b01, 1'b0, 1'b1);

    for (int n = 0; n < 300; n++) begin
      applyStimulus(CH'($urandom), 2'($urandom_range(1, 3)), 1'b0, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
